// File: rtl/alert_scheduler.sv
// alert_scheduler: round-robin owner of the board LED and buzzer.
// Each granted requester gets cnt ON/OFF pulses (LED lit, buzzer toggling
// during ON), then a silent gap, then the grant is released.
//
//   state | meaning
//   IDLE  | no service; arbitrate among pending requests
//   ON    | LED lit, buzzer square wave, ON_CYC cycles
//   OFF   | dark and silent between pulses, OFF_CYC cycles
//   GAP   | trailing silence, GAP_CYC cycles; done on its last cycle
module alert_scheduler #(
   parameter int N         = 4,
   parameter int CW        = 4,
   parameter int ON_CYC    = 5_000_000,
   parameter int OFF_CYC   = 5_000_000,
   parameter int GAP_CYC   = 25_000_000,
   parameter int TONE_HALF = 10_000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic [N*CW-1:0] cnt_in,
   output logic [N-1:0]    grant,
   output logic [N-1:0]    done,
   output logic            busy,
   output logic            led,
   output logic            beep
);

   localparam int PW    = (N > 1) ? $clog2(N) : 1;
   localparam int MAX_A = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
   localparam int MAX_B = (GAP_CYC > TONE_HALF) ? GAP_CYC : TONE_HALF;
   localparam int MAXV  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int TW    = $clog2(MAXV + 1);

   localparam logic [TW-1:0] ON_LD   = TW'(ON_CYC - 1);
   localparam logic [TW-1:0] OFF_LD  = TW'(OFF_CYC - 1);
   localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYC - 1);
   localparam logic [TW-1:0] TONE_LD = TW'(TONE_HALF - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF, ST_GAP} state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   ptr, ptr_nxt;
   logic [CW-1:0]   rem, rem_nxt;
   logic [TW-1:0]   phase, phase_nxt;
   logic [TW-1:0]   tone, tone_nxt;
   logic [N-1:0]    grant_q, grant_nxt;
   logic [N-1:0]    done_q, done_nxt;
   logic            led_q, led_nxt;
   logic            beep_q, beep_nxt;

   logic [CW-1:0]   cnt_fld [N];
   logic [PW-1:0]   sel;
   logic [PW-1:0]   idx;
   logic            found;
   logic            go_on, go_gap;

   // Split the packed count bus into per-requester fields.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         cnt_fld[i] = cnt_in[i*CW +: CW];
      end
   end

   // Round-robin pick: first pending request at or above the pointer, wrapping.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = PW'((int'(ptr) + k) % N);
         if (!found && req[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   // Next-state and next-output logic; phase entries are applied after the case.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      rem_nxt   = rem;
      phase_nxt = phase;
      tone_nxt  = tone;
      grant_nxt = grant_q;
      done_nxt  = '0;
      led_nxt   = 1'b0;
      beep_nxt  = 1'b0;
      go_on     = 1'b0;
      go_gap    = 1'b0;

      case (state)
         ST_IDLE: begin
            if (found) begin
               grant_nxt      = '0;
               grant_nxt[sel] = 1'b1;
               rem_nxt        = cnt_fld[sel];
               ptr_nxt        = (sel == PW'(N - 1)) ? '0 : sel + PW'(1);
               if (cnt_fld[sel] != '0) go_on = 1'b1;
               else                    go_gap = 1'b1;
            end
         end
         ST_ON: begin
            if (phase == '0) begin
               rem_nxt   = rem - CW'(1);
               state_nxt = ST_OFF;
               phase_nxt = OFF_LD;
            end else begin
               phase_nxt = phase - TW'(1);
               led_nxt   = 1'b1;
               if (tone == '0) begin
                  beep_nxt = ~beep_q;
                  tone_nxt = TONE_LD;
               end else begin
                  beep_nxt = beep_q;
                  tone_nxt = tone - TW'(1);
               end
            end
         end
         ST_OFF: begin
            if (phase == '0) begin
               if (rem != '0) go_on = 1'b1;
               else           go_gap = 1'b1;
            end else begin
               phase_nxt = phase - TW'(1);
            end
         end
         default: begin
            if (phase == '0) begin
               state_nxt = ST_IDLE;
               grant_nxt = '0;
            end else begin
               phase_nxt = phase - TW'(1);
            end
         end
      endcase

      // Tone timer restarts on every ON entry so all pulses sound alike.
      if (go_on) begin
         state_nxt = ST_ON;
         phase_nxt = ON_LD;
         tone_nxt  = TONE_LD;
         led_nxt   = 1'b1;
         beep_nxt  = 1'b0;
      end
      if (go_gap) begin
         state_nxt = ST_GAP;
         phase_nxt = GAP_LD;
      end

      if (state_nxt == ST_GAP && phase_nxt == '0) done_nxt = grant_nxt;
   end

   // State and output registers; reset aborts any service without a done.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         ptr     <= '0;
         rem     <= '0;
         phase   <= '0;
         tone    <= '0;
         grant_q <= '0;
         done_q  <= '0;
         led_q   <= 1'b0;
         beep_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         ptr     <= ptr_nxt;
         rem     <= rem_nxt;
         phase   <= phase_nxt;
         tone    <= tone_nxt;
         grant_q <= grant_nxt;
         done_q  <= done_nxt;
         led_q   <= led_nxt;
         beep_q  <= beep_nxt;
      end
   end

   assign grant = grant_q;
   assign done  = done_q;
   assign busy  = (state != ST_IDLE);
   assign led   = led_q;
   assign beep  = beep_q;

endmodule

// File: tb/tb_alert_scheduler.sv
// tb_alert_scheduler: scoreboard bench; each service's cycle-by-cycle output
// trace is built from the pattern description and queued when the request is
// driven, then popped and compared one cycle at a time.
module tb_alert_scheduler;

   localparam int ON_C  = 8;
   localparam int OFF_C = 4;
   localparam int GAP_C = 6;
   localparam int T_HALF = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] cnt_in;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic        busy;
   logic        led;
   logic        beep;

   logic [10:0] exp_q [$];
   int          n_total = 0;
   int          n_bad   = 0;

   alert_scheduler #(
      .N(4), .CW(4), .ON_CYC(ON_C), .OFF_CYC(OFF_C), .GAP_CYC(GAP_C), .TONE_HALF(T_HALF)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .cnt_in(cnt_in),
      .grant(grant), .done(done), .busy(busy), .led(led), .beep(beep)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] pack(input logic [3:0] g, input logic [3:0] d,
                                        input logic b, input logic l, input logic t);
      return {g, d, b, l, t};
   endfunction

   function automatic logic [10:0] outs();
      return {grant, done, busy, led, beep};
   endfunction

   // Expected trace of one service (cycles after the arbitration edge),
   // followed by the IDLE cycle that separates it from the next one.
   task automatic push_service(input int idx, input int k);
      logic [3:0] g;
      logic       t;
      g = 4'b0001 << idx;
      for (int p = 0; p < k; p++) begin
         for (int c = 0; c < ON_C; c++) begin
            t = (((c / T_HALF) % 2) == 1);
            exp_q.push_back(pack(g, 4'b0000, 1'b1, 1'b1, t));
         end
         for (int c = 0; c < OFF_C; c++) exp_q.push_back(pack(g, 4'b0000, 1'b1, 1'b0, 1'b0));
      end
      for (int c = 0; c < GAP_C; c++)
         exp_q.push_back(pack(g, (c == GAP_C - 1) ? g : 4'b0000, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(pack(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0));
   endtask

   // Pop and compare one entry per cycle; optional input change at step chg_at.
   // req is withdrawn after the final done so no new service starts.
   task automatic drain(input string tag, input int max_steps, input int chg_at,
                        input logic [3:0] chg_req, input logic [15:0] chg_cnt);
      int          step;
      logic [10:0] e;
      step = 0;
      while (exp_q.size() > 0 && step < max_steps) begin
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         step++;
         chk($sformatf("%s_step%0d", tag, step), 32'(outs()), 32'(e));
         if (step == chg_at) begin
            req    = chg_req;
            cnt_in = chg_cnt;
         end
         if (exp_q.size() == 1) req = 4'b0000;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst    = 1'b0;
      req    = 4'hF;
      cnt_in = 16'h1111;

      repeat (3) begin
         @(posedge clk);
         #1;
         chk("reset_hold", 32'(outs()), 32'd0);
      end

      // Release with all four requesting: round-robin from requester 0.
      rst = 1'b1;
      push_service(0, 1);
      push_service(1, 1);
      push_service(2, 1);
      push_service(3, 1);
      push_service(0, 1);
      drain("rr", 1000, -1, 4'b0000, 16'h0000);

      // Single request with three pulses; pointer is at 1.
      req    = 4'b0010;
      cnt_in = 16'h0030;
      push_service(1, 3);
      drain("single", 1000, -1, 4'b0000, 16'h0000);

      // Zero count: straight to the gap.
      req    = 4'b0100;
      cnt_in = 16'h0000;
      push_service(2, 0);
      drain("zero", 1000, -1, 4'b0000, 16'h0000);

      // Inputs change during ON; latched count of 2 must still be played.
      req    = 4'b1000;
      cnt_in = 16'h2000;
      push_service(3, 2);
      drain("midchg", 1000, 3, 4'b0000, 16'hFFFF);

      // Reset during OFF: outputs clear at once and no done appears.
      req    = 4'b0010;
      cnt_in = 16'h0020;
      push_service(1, 2);
      drain("abort", 10, -1, 4'b0000, 16'h0000);
      rst = 1'b0;
      #1;
      chk("abort_now", 32'(outs()), 32'd0);
      exp_q.delete();
      req    = 4'b1001;
      cnt_in = 16'h0001;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("abort_hold", 32'(outs()), 32'd0);
      end

      // Pointer must be back at 0, so requester 0 wins over requester 3.
      rst = 1'b1;
      push_service(0, 1);
      drain("post_rst", 1000, -1, 4'b0000, 16'h0000);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
